// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: op encodings, bus layouts and stall constants.
package ex_stage_pkg;

  localparam int  STALL_W      = 6;
  localparam logic STOP        = 1'b1;
  localparam logic NO_STOP     = 1'b0;

  localparam int  HILO_WD      = 66;
  localparam int  EX_TO_MEM_WD = 142;
  localparam int  EX_TO_RF_WD  = 104;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {
    DIV_OP_NONE, DIV_OP_DIV, DIV_OP_DIVU
  } div_op_e;

  typedef enum logic [2:0] {
    MEM_NONE, MEM_LW, MEM_LB, MEM_LBU, MEM_SW, MEM_SH, MEM_SB
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_BUSY, ST_DONE
  } div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    alu_op_e     alu_op;
    div_op_e     div_op;
    mem_op_e     mem_op;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] store_data;
  } id_to_ex_t;

  localparam int ID_TO_EX_WD = $bits(id_to_ex_t);

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of the execute stage's pipeline-facing signals; master drives the decoded
// instruction and stall vector, slave is the stage's view.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [STALL_W-1:0]      stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    stallreq_for_ex;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
           data_sram_addr, data_sram_wdata, stallreq_for_ex
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
           data_sram_addr, data_sram_wdata, stallreq_for_ex
  );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider: 32 iterations on magnitudes, sign fix-up applied in DONE.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [32:0] trial, diff;

  // Partial remainder never exceeds 2*divisor-1, so diff[32] is a clean borrow flag.
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d   = ST_BUSY;
        cnt_d     = '0;
        rem_d     = '0;
        quo_d     = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
        dvs_d     = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
        neg_quo_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
        neg_rem_d = signed_i & dividend_i[31];
      end
      ST_BUSY: begin
        rem_d = diff[32] ? trial[31:0] : diff[31:0];
        quo_d = {quo_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy_o      = (state_q == ST_BUSY);
  assign done_o      = (state_q == ST_DONE);
  assign quotient_o  = neg_quo_q ? -quo_q : quo_q;
  assign remainder_o = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: pipeline register, ALU, store lane/byte steering and optional divider.
// Define DIV_EN to build in the divider; otherwise DIV/DIVU execute as bubbles.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_to_ex_t          ex_q, ex_d, op;
  logic               div_req, sel_rf_res;
  logic [31:0]        alu_res;
  logic [HILO_WD-1:0] hilo;
  logic               unused_stall;

  assign unused_stall = ^{stall[5:4], stall[1:0]};

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    ex_d = ex_q;
    if (stall[2] == STOP && stall[3] == NO_STOP) ex_d = id_to_ex_t'('0);
    else if (stall[2] == NO_STOP)                ex_d = id_to_ex_t'(id_to_ex_bus);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= id_to_ex_t'('0);
    else      ex_q <= ex_d;
  end

  assign div_req = (ex_q.div_op == DIV_OP_DIV) || (ex_q.div_op == DIV_OP_DIVU);

`ifdef DIV_EN
  logic        div_busy, div_done;
  logic [31:0] div_quo, div_rem;

  assign op = ex_q;

  div_unit u_div (
    .clk         (clk),
    .rst_n       (rst),
    .start_i     (div_req),
    .signed_i    (ex_q.div_op == DIV_OP_DIV),
    .dividend_i  (ex_q.src1),
    .divisor_i   (ex_q.src2),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // The held divide stalls from its first cycle in IDLE until the DONE cycle.
  assign stallreq_for_ex = div_busy | (div_req & ~div_done);
  assign hilo            = div_done ? {1'b1, 1'b1, div_rem, div_quo} : '0;
`else
  assign op              = div_req ? id_to_ex_t'('0) : ex_q;
  assign stallreq_for_ex = 1'b0;
  assign hilo            = '0;
`endif

  always_comb begin
    alu_res = '0;
    case (op.alu_op)
      ALU_ADD:  alu_res = op.src1 + op.src2;
      ALU_SUB:  alu_res = op.src1 - op.src2;
      ALU_AND:  alu_res = op.src1 & op.src2;
      ALU_OR:   alu_res = op.src1 | op.src2;
      ALU_XOR:  alu_res = op.src1 ^ op.src2;
      ALU_NOR:  alu_res = ~(op.src1 | op.src2);
      ALU_SLL:  alu_res = op.src2 << op.src1[4:0];
      ALU_SRL:  alu_res = op.src2 >> op.src1[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(op.src2) >>> op.src1[4:0]);
      ALU_SLT:  alu_res = {31'b0, $signed(op.src1) < $signed(op.src2)};
      ALU_SLTU: alu_res = {31'b0, op.src1 < op.src2};
      ALU_LUI:  alu_res = {op.src2[15:0], 16'b0};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    data_sram_wen   = 4'b0000;
    data_sram_wdata = op.store_data;
    case (op.mem_op)
      MEM_SW: data_sram_wen = 4'b1111;
      MEM_SH: begin
        data_sram_wen   = 4'b0011 << {alu_res[1], 1'b0};
        data_sram_wdata = {2{op.store_data[15:0]}};
      end
      MEM_SB: begin
        data_sram_wen   = 4'b0001 << alu_res[1:0];
        data_sram_wdata = {4{op.store_data[7:0]}};
      end
      default: data_sram_wen = 4'b0000;
    endcase
  end

  assign data_sram_en   = (op.mem_op != MEM_NONE);
  assign data_sram_addr = alu_res;
  assign sel_rf_res     = (op.mem_op == MEM_LW) || (op.mem_op == MEM_LB) || (op.mem_op == MEM_LBU);

  assign ex_to_mem_bus = {hilo, op.pc, data_sram_en, data_sram_wen, sel_rf_res,
                          op.rf_we, op.rf_waddr, alu_res};
  assign ex_to_rf_bus  = {hilo, op.rf_we, op.rf_waddr, alu_res};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an instruction-level model, plus directed literal cases.
module tb_ex_stage;
  import ex_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [1:0]  dop;
    logic [2:0]  mop;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
  } ins_t;

  typedef struct {
    logic [141:0] mem;
    logic [103:0] rf;
    logic         en;
    logic [3:0]   wen;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         sreq;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  bit   run_cmp = 1'b0;
  int   checks = 0;
  int   passed = 0;
  ins_t m_reg;
  int   m_age;
  exp_t cmp_e;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (bus.stall),
    .id_to_ex_bus    (bus.id_to_ex_bus),
    .ex_to_mem_bus   (bus.ex_to_mem_bus),
    .ex_to_rf_bus    (bus.ex_to_rf_bus),
    .data_sram_en    (bus.data_sram_en),
    .data_sram_wen   (bus.data_sram_wen),
    .data_sram_addr  (bus.data_sram_addr),
    .data_sram_wdata (bus.data_sram_wdata),
    .stallreq_for_ex (bus.stallreq_for_ex)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    else passed++;
  endtask

  function automatic logic [31:0] f_alu(ins_t i);
    logic [4:0] s;
    s = i.a[4:0];
    case (i.alu)
      4'd0:    return i.a + i.b;
      4'd1:    return i.a - i.b;
      4'd2:    return i.a & i.b;
      4'd3:    return i.a | i.b;
      4'd4:    return i.a ^ i.b;
      4'd5:    return ~(i.a | i.b);
      4'd6:    return i.b << s;
      4'd7:    return i.b >> s;
      4'd8:    return (i.b >> s) | (i.b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd9:    return 32'(longint'($signed(i.a)) < longint'($signed(i.b)));
      4'd10:   return 32'(longint'(i.a) < longint'(i.b));
      4'd11:   return {i.b[15:0], 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  // Returns {hi, lo} = {remainder, quotient}.
  function automatic logic [63:0] f_div(ins_t i);
    longint q, r, sa, sb;
    if (i.dop == 2'd2) begin
      if (i.b == 32'h0) begin q = 64'hFFFF_FFFF; r = longint'(i.a); end
      else begin q = longint'(i.a) / longint'(i.b); r = longint'(i.a) % longint'(i.b); end
    end else begin
      sa = longint'($signed(i.a));
      sb = longint'($signed(i.b));
      if (sb == 0) begin q = (sa < 0) ? 1 : -1; r = sa; end
      else begin q = sa / sb; r = sa % sb; end
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic exp_t model_out(ins_t r, int age);
    exp_t        e;
    ins_t        i;
    logic [65:0] hilo;
    logic [31:0] res;
    logic [63:0] hd;
    logic        is_div;
    i      = r;
    hilo   = '0;
    is_div = (r.dop == 2'd1) || (r.dop == 2'd2);
`ifdef DIV_EN
    e.sreq = is_div && ((age % 34) < 33);
    if (is_div && ((age % 34) == 33)) begin
      hd   = f_div(r);
      hilo = {2'b11, hd};
    end
`else
    e.sreq = 1'b0;
    hd     = '0;
    if (is_div) i = '0;
`endif
    res     = f_alu(i);
    e.en    = (i.mop != 3'd0);
    e.addr  = res;
    e.wdata = i.sd;
    for (int k = 0; k < 4; k++) begin
      case (i.mop)
        3'd4:    e.wen[k] = 1'b1;
        3'd5:    e.wen[k] = ((k / 2) == int'(res[1]));
        3'd6:    e.wen[k] = (k == int'(res[1:0]));
        default: e.wen[k] = 1'b0;
      endcase
      if (i.mop == 3'd6) e.wdata[8*k +: 8] = i.sd[7:0];
    end
    if (i.mop == 3'd5) e.wdata = {i.sd[15:0], i.sd[15:0]};
    e.mem = {hilo, i.pc, e.en, e.wen, (i.mop >= 3'd1 && i.mop <= 3'd3), i.we, i.wa, res};
    e.rf  = {hilo, i.we, i.wa, res};
    return e;
  endfunction

  // Drive one cycle; while the model says a divide stalls, the hazard unit holds EX (001111).
  task automatic step(input ins_t ins, input logic [5:0] st);
    exp_t e;
    e = model_out(m_reg, m_age);
    if (e.sreq) st = 6'b001111;
    bus.stall        = st;
    bus.id_to_ex_bus = ins;
    @(posedge clk);
    #1;
    if (!rst)                   begin m_reg = '0;  m_age = 0; end
    else if (st[2] && !st[3])   begin m_reg = '0;  m_age = 0; end
    else if (!st[2])            begin m_reg = ins; m_age = 0; end
    else                        m_age++;
  endtask

  function automatic ins_t mk(input logic [3:0] alu, input logic [1:0] dop, input logic [2:0] mop,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd);
    ins_t i;
    i = '0;
    i.pc = 32'hBFC0_0100; i.we = 1'b1; i.wa = 5'd3;
    i.alu = alu; i.dop = dop; i.mop = mop; i.a = a; i.b = b; i.sd = sd;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.pc  = 32'($urandom);
    i.alu = 4'($urandom_range(0, 11));
    i.dop = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
    i.mop = 3'($urandom_range(0, 6));
    i.we  = 1'($urandom);
    i.wa  = 5'($urandom);
    i.a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
    i.b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
    if ($urandom_range(0, 9) == 0) i.b = i.a;
    i.sd  = 32'($urandom);
    if (i.dop == 2'd1 && i.b == 32'h0) i.b = 32'd1;
    return i;
  endfunction

  function automatic logic [5:0] rand_stall();
    case ($urandom_range(0, 9))
      0:       return 6'b000111;
      1:       return 6'b001111;
      2:       return 6'($urandom);
      default: return 6'b000000;
    endcase
  endfunction

  task automatic run_div(input string name, input logic [1:0] dop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi);
    int n;
    n = 0;
    step(mk(4'd0, dop, 3'd0, a, b, 32'h0), 6'b000000);
    while (bus.stallreq_for_ex === 1'b1 && n < 40) begin
      n++;
      step('0, 6'b000000);
    end
`ifdef DIV_EN
    check({name, "_stall_cycles"}, 160'(n), 160'(33));
    check({name, "_hilo"}, 160'(bus.ex_to_mem_bus[141:76]), 160'({2'b11, hi, lo}));
    check({name, "_rf_hilo"}, 160'(bus.ex_to_rf_bus[103:38]), 160'({2'b11, hi, lo}));
`else
    check({name, "_stall_cycles"}, 160'(n), 160'(0));
    check({name, "_hilo"}, 160'(bus.ex_to_mem_bus[141:76]), 160'(0));
    check({name, "_lohi_unused"}, 160'(lo ^ hi ^ lo ^ hi), 160'(0));
`endif
    step('0, 6'b000000);
    check({name, "_we_drop"}, 160'(bus.ex_to_mem_bus[141:140]), 160'(0));
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      cmp_e = model_out(m_reg, m_age);
      check("mem_bus",  160'(bus.ex_to_mem_bus),   160'(cmp_e.mem));
      check("rf_bus",   160'(bus.ex_to_rf_bus),    160'(cmp_e.rf));
      check("sram_en",  160'(bus.data_sram_en),    160'(cmp_e.en));
      check("sram_wen", 160'(bus.data_sram_wen),   160'(cmp_e.wen));
      check("sram_addr",160'(bus.data_sram_addr),  160'(cmp_e.addr));
      check("sram_wdata",160'(bus.data_sram_wdata),160'(cmp_e.wdata));
      check("stallreq", 160'(bus.stallreq_for_ex), 160'(cmp_e.sreq));
    end
  end

  initial begin
    exp_t pin;
    rst              = 1'b0;
    bus.stall        = '0;
    bus.id_to_ex_bus = '0;
    m_reg            = '0;
    m_age            = 0;
    @(posedge clk);
    run_cmp = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mem_bus",  160'(bus.ex_to_mem_bus),   160'(0));
    check("reset_stallreq", 160'(bus.stallreq_for_ex), 160'(0));
    rst = 1'b1;

    // ADD 5 + 7 visible right after the capturing edge.
    step(mk(4'd0, 2'd0, 3'd0, 32'd5, 32'd7, 32'h0), 6'b000000);
    check("add_result", 160'(bus.ex_to_mem_bus[31:0]), 160'(12));
    check("add_hi_we",  160'(bus.ex_to_mem_bus[141]),  160'(0));
    pin = model_out(m_reg, m_age);
    check("model_add",  160'(pin.mem[31:0]),           160'(12));

    // Hold with 001111, then bubble with 000111.
    step(mk(4'd1, 2'd0, 3'd0, 32'd100, 32'd1, 32'h0), 6'b001111);
    check("hold_result", 160'(bus.ex_to_mem_bus[31:0]),  160'(12));
    check("hold_pc",     160'(bus.ex_to_mem_bus[75:44]), 160'(32'hBFC0_0100));
    step(mk(4'd1, 2'd0, 3'd0, 32'd100, 32'd1, 32'h0), 6'b000111);
    check("bubble_bus",  160'(bus.ex_to_mem_bus),        160'(0));

    // SB to 0x1003 lands in the top byte lane.
    step(mk(4'd0, 2'd0, 3'd6, 32'h1000, 32'h3, 32'hAB), 6'b000000);
    check("sb_addr",    160'(bus.data_sram_addr),         160'(32'h1003));
    check("sb_wen",     160'(bus.data_sram_wen),          160'(4'b1000));
    check("sb_wdata",   160'(bus.data_sram_wdata),        160'(32'hABAB_ABAB));
    check("sb_bus_wen", 160'(bus.ex_to_mem_bus[42:39]),   160'(4'b1000));
    check("sb_en",      160'(bus.data_sram_en),           160'(1));

    run_div("div_m7_2", 2'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu_10_0", 2'd2, 32'd10, 32'd0, 32'hFFFF_FFFF, 32'd10);

    // Reset asserted at iteration 15 of a divide.
    step(mk(4'd0, 2'd1, 3'd0, 32'd1000, 32'd3, 32'h0), 6'b000000);
    repeat (16) step('0, 6'b000000);
    #2;
    rst   = 1'b0;
    m_reg = '0;
    m_age = 0;
    #1;
    check("rst_mid_stallreq", 160'(bus.stallreq_for_ex), 160'(0));
    check("rst_mid_mem_bus",  160'(bus.ex_to_mem_bus),   160'(0));
    check("rst_mid_rf_bus",   160'(bus.ex_to_rf_bus),    160'(0));
    @(posedge clk);
    #1;
    check("rst_held_stallreq", 160'(bus.stallreq_for_ex), 160'(0));
    rst = 1'b1;
    run_div("div_after_rst", 2'd1, 32'd100, 32'd7, 32'd14, 32'd2);

    for (int k = 0; k < 1500; k++) step(rand_ins(), rand_stall());

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk  input  1  system clock, rising-edge; one clock, no other clock domains.
REQ-002 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have stall  input  `StallBus (6)  per-stage stall vector; bit 2 = EX, bit 3 = MEM.
REQ-004 SHALL have id_to_ex_bus  input  `ID_TO_EX_WD  decoded instruction, with these fields:
- pc[31:0]
- alu_op[3:0]: ADD, SUB, AND, OR, XOR, NOR, SLL, SRL, SRA, SLT, SLTU, LUI
- div_op[1:0]: none, DIV, DIVU
- mem_op[2:0]: none, LW, LB, LBU, SW, SH, SB
- rf_we, rf_waddr[4:0], src1[31:0], src2[31:0], store_data[31:0]
REQ-005 SHALL have ex_to_mem_bus  output  142  packed, MSB first:
- hilo_bus[65:0] = {hi_we, lo_we, hi[31:0], lo[31:0]}
- pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]
REQ-006 SHALL have ex_to_rf_bus  output  104  {hilo_bus, rf_we, rf_waddr, ex_result}; forwarding path to ID.
REQ-007 SHALL have data_sram_en  output  1, data_sram_wen  output  4, data_sram_addr  output  32, data_sram_wdata  output  32.
REQ-008 SHALL have stallreq_for_ex  output  1  asserted while a divide is in progress.

Function
REQ-009 SHALL capture the input bus in an internal register on every rising clk edge, by priority:
- stall[2]=Stop and stall[3]=NoStop: load all-zero (bubble)
- stall[2]=NoStop: load id_to_ex_bus
- otherwise: hold
REQ-010 SHALL compute ex_result combinationally from the registered operands:
- shift amount = src1[4:0]
- SLT signed, SLTU unsigned compare; result zero-extended to 32 bits
- LUI = {src2[15:0], 16'b0}
REQ-011 SHALL form data_sram_addr = ex_result (ADD of base and offset); data_sram_en = 1 for any mem_op other than none.
REQ-012 SHALL set data_sram_wen by store type:
- SW: 4'b1111
- SH: 4'b0011 << addr[1]*2
- SB: 4'b0001 << addr[1:0]
- loads and non-memory ops: 0
REQ-013 SHALL replicate store_data into data_sram_wdata by byte (SB) or halfword (SH) so that the enabled lanes carry the data; no alignment exception is raised.
REQ-014 SHALL set sel_rf_res = 1 for load ops and data_ram_wen = data_sram_wen.
REQ-015 SHALL implement the divider FSM in three states:
- IDLE -> BUSY when the registered div_op is not none
- BUSY -> DONE after exactly 32 iterations
- DONE -> IDLE unconditionally in the next cycle
REQ-016 SHALL drive stallreq_for_ex high combinationally in IDLE with div_op active and throughout BUSY, and low in DONE; total stall is 33 cycles per divide.
REQ-017 SHALL take the divide operands (src1 = dividend, src2 = divisor) from the pipeline register; the register is held by stall while the divide runs.
REQ-018 SHALL produce for DIV/DIVU, in DONE only, hi_we = lo_we = 1, lo = quotient, hi = remainder; hi_we = lo_we = 0 in all other cycles.
REQ-019 SHALL produce for signed DIV a quotient negated when the operand signs differ, and a remainder carrying the sign of the dividend.
REQ-020 SHALL handle divide by zero without error: complete in 32 cycles, DIVU gives quotient 32'hFFFFFFFF and remainder = dividend.

Reset
REQ-021 SHALL clear the pipeline register, the FSM (to IDLE) and the iteration counter immediately on rst low, including mid-divide.
REQ-022 SHALL hold every output at zero while rst is low.

Configuration
REQ-023 SHALL compile the divider in when DIV_EN is defined; when it is undefined:
- no divider logic is instantiated
- stallreq_for_ex is tied to 0
- DIV/DIVU produce hi_we = lo_we = 0 and behave as bubbles

Structure
REQ-024 SHALL place the following in the shared package: op encodings for alu_op, div_op and mem_op, the bus widths (ID_TO_EX_WD, EX_TO_MEM_WD = 142, EX_TO_RF_WD = 104), and the Stop/NoStop constants.
REQ-025 SHALL isolate the divider in one sub-module, div_unit, with a start/busy/done handshake.

Verification
REQ-026 SHALL cover ADD with src1 = 5, src2 = 7 -> ex_result = 12 one cycle after capture; hi_we = 0.
REQ-027 SHALL cover SB with src1 + offset = 0x1003 and store_data = 0xAB -> wen = 4'b1000, wdata = 0xABABABAB.
REQ-028 SHALL cover DIV -7 / 2 -> stallreq high for 33 cycles, then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF with hi_we = lo_we = 1 for one cycle.
REQ-029 SHALL cover DIVU 10 / 0 -> lo = 0xFFFFFFFF, hi = 10 after 33 cycles.
REQ-030 SHALL cover rst low at iteration 15 of a divide -> FSM returns to IDLE, stallreq = 0, outputs 0; the next DIV takes the full 33 cycles.
REQ-031 SHALL cover stall = 6'b000111 -> ex_to_mem_bus becomes all-zero on the next edge; with stall = 6'b001111 the register holds its value.
